// File: rtl/core_trace_buffer_if.sv
// Retire-side capture bus and valid/ready readout port for the core trace buffer.
// The master modport is the core side and the trace consumer. The slave modport is the trace buffer.
interface core_trace_buffer_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
);
    logic                            retire;
    logic [PC_WIDTH-1:0]             pc_in;
    logic [INSTR_WIDTH-1:0]          ir_in;
    logic [2:0]                      flags_in;
    logic                            rd_valid;
    logic                            rd_ready;
    logic [PC_WIDTH+INSTR_WIDTH+2:0] rd_data;

    modport master (
        output retire, pc_in, ir_in, flags_in, rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  retire, pc_in, ir_in, flags_in, rd_ready,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/core_trace_buffer.sv
// Triggerable instruction-trace buffer: captures {flags, ir, pc} of retired instructions
// after a PC trigger, then drains them oldest-first through a show-ahead valid/ready port.
module core_trace_buffer #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int DEPTH       = 16,
    parameter int RING_MODE   = 0
) (
    input  logic                       clock_50,
    input  logic                       reset_n,
    core_trace_buffer_if.slave         bus,
    input  logic                       arm,
    input  logic                       stop,
    input  logic                       trig_en,
    input  logic [PC_WIDTH-1:0]        trig_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic [1:0]                 state_o,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = PC_WIDTH + INSTR_WIDTH + 3;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            first_done_q, first_done_d;
    logic            wr_en;
    logic            rd_fire;
    logic            trig_hit;
    logic            rd_valid_int;
    logic [DW-1:0]   mem [DEPTH];

    assign trig_hit     = !trig_en || (bus.pc_in == trig_pc);
    assign rd_valid_int = ((state_q == IDLE) || (state_q == DONE)) && (count_q != '0);
    assign rd_fire      = rd_valid_int && bus.rd_ready;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        wr_en        = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    // Arming discards any unread entries, even if a read is offered this edge.
                    state_d    = ARMED;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end else begin
                    if (rd_fire) begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        count_d  = count_q - CW'(1);
                    end
                    if (RING_MODE == 0 && state_q == DONE && first_done_q &&
                        bus.retire && count_q == FULL) begin
                        overflow_d = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (bus.retire && trig_hit) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    count_d  = CW'(1);
                    state_d  = CAPTURE;
                end
                if (stop) state_d = DONE;
            end
            CAPTURE: begin
                if (bus.retire) begin
                    if (count_q == FULL) begin
                        // Full buffer in ring mode: the oldest entry is replaced.
                        overflow_d = 1'b1;
                        if (RING_MODE != 0) begin
                            wr_en    = 1'b1;
                            wr_ptr_d = wr_ptr_q + PW'(1);
                            rd_ptr_d = rd_ptr_q + PW'(1);
                        end
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        count_d  = count_q + CW'(1);
                        if (RING_MODE == 0 && count_q == FULL - CW'(1)) state_d = DONE;
                    end
                end
                if (stop) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        first_done_d = (state_d == DONE) && (state_q != DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            first_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            first_done_q <= first_done_d;
        end
    end

    // NOTE: the trace storage has no reset; only pointers and count define which entries are valid.
    always_ff @(posedge clock_50) begin
        if (wr_en) mem[wr_ptr_q] <= {bus.flags_in, bus.ir_in, bus.pc_in};
    end

    assign bus.rd_valid = rd_valid_int;
    assign bus.rd_data  = rd_valid_int ? mem[rd_ptr_q] : '0;
    assign count        = count_q;
    assign state_o      = state_q;
    assign overflow     = overflow_q;
endmodule

// File: tb/tb_core_trace_buffer.sv
// Directed bench for core_trace_buffer: a stop-mode instance (dut0) and a ring-mode instance (dut1),
// both with DEPTH=4, exercised through trigger, overwrite, stop, backpressure, re-arm and reset scenarios.
module tb_core_trace_buffer;
    localparam int PW = 8;
    localparam int IW = 16;
    localparam int D  = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       arm0, stop0, te0, arm1, stop1, te1;
    logic [7:0] tp0, tp1;
    logic [2:0] cnt0, cnt1;
    logic [1:0] st0, st1;
    logic       ovf0, ovf1;
    int         n_cmp  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    core_trace_buffer_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus0 ();
    core_trace_buffer_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus1 ();

    core_trace_buffer #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DEPTH(D), .RING_MODE(0)) dut0 (
        .clock_50(clk), .reset_n(reset_n), .bus(bus0.slave), .arm(arm0), .stop(stop0),
        .trig_en(te0), .trig_pc(tp0), .count(cnt0), .state_o(st0), .overflow(ovf0)
    );

    core_trace_buffer #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DEPTH(D), .RING_MODE(1)) dut1 (
        .clock_50(clk), .reset_n(reset_n), .bus(bus1.slave), .arm(arm1), .stop(stop1),
        .trig_en(te1), .trig_pc(tp1), .count(cnt1), .state_o(st1), .overflow(ovf1)
    );

    function automatic logic [26:0] e0(input logic [7:0] pc);
        logic [15:0] ir;
        ir = 16'hA000 + {8'h00, pc};
        return {3'b010, ir, pc};
    endfunction

    function automatic logic [26:0] e1(input logic [7:0] pc);
        logic [15:0] ir;
        ir = 16'hA000 + {8'h00, pc};
        return {pc[2:0], ir, pc};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ret0(input logic [7:0] pc);
        bus0.retire = 1'b1; bus0.pc_in = pc; bus0.ir_in = 16'hA000 + {8'h00, pc}; bus0.flags_in = 3'b010;
        tick();
        bus0.retire = 1'b0;
    endtask

    task automatic ret1(input logic [7:0] pc);
        bus1.retire = 1'b1; bus1.pc_in = pc; bus1.ir_in = 16'hA000 + {8'h00, pc}; bus1.flags_in = pc[2:0];
        tick();
        bus1.retire = 1'b0;
    endtask

    task automatic pulse_arm0(); arm0 = 1'b1; tick(); arm0 = 1'b0; endtask
    task automatic pulse_arm1(); arm1 = 1'b1; tick(); arm1 = 1'b0; endtask
    task automatic pulse_stop1(); stop1 = 1'b1; tick(); stop1 = 1'b0; endtask

    task automatic test_reset();
        tick();
        n_cmp++; if (st0 !== 2'd0) begin n_fail++; $display("FAIL reset_state0: got %0d want 0", st0); end
        n_cmp++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL reset_count0: got %0d want 0", cnt0); end
        n_cmp++; if (bus0.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid0: got %b want 0", bus0.rd_valid); end
        n_cmp++; if (bus0.rd_data !== 27'd0) begin n_fail++; $display("FAIL reset_data0: got %h want 0", bus0.rd_data); end
        n_cmp++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf0: got %b want 0", ovf0); end
        n_cmp++; if (st1 !== 2'd0) begin n_fail++; $display("FAIL reset_state1: got %0d want 0", st1); end
        reset_n = 1'b1;
        tick();
        pulse_stop1();
        n_cmp++; if (st1 !== 2'd0) begin n_fail++; $display("FAIL idle_stop_ignored: got %0d want 0", st1); end
    endtask

    task automatic test_trigger_stop_mode();
        int exp_st, exp_cnt;
        te0 = 1'b1; tp0 = 8'h05;
        pulse_arm0();
        n_cmp++; if (st0 !== 2'd1) begin n_fail++; $display("FAIL trig_armed: got %0d want 1", st0); end
        for (int p = 1; p <= 10; p++) begin
            ret0(8'(p));
            if (p < 5)      begin exp_st = 1; exp_cnt = 0;     end
            else if (p < 8) begin exp_st = 2; exp_cnt = p - 4; end
            else            begin exp_st = 3; exp_cnt = 4;     end
            n_cmp++; if (st0 !== 2'(exp_st)) begin n_fail++; $display("FAIL trig_state pc=%0h: got %0d want %0d", p, st0, exp_st); end
            n_cmp++; if (cnt0 !== 3'(exp_cnt)) begin n_fail++; $display("FAIL trig_count pc=%0h: got %0d want %0d", p, cnt0, exp_cnt); end
        end
        n_cmp++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL trig_full_retire_ovf: got %b want 1", ovf0); end
        bus0.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus0.rd_valid !== 1'b1) begin n_fail++; $display("FAIL trig_rd_valid %0d: got %b want 1", i, bus0.rd_valid); end
            n_cmp++; if (bus0.rd_data !== e0(8'(5 + i))) begin n_fail++; $display("FAIL trig_rd_data %0d: got %h want %h", i, bus0.rd_data, e0(8'(5 + i))); end
            tick();
        end
        bus0.rd_ready = 1'b0;
        n_cmp++; if (bus0.rd_valid !== 1'b0) begin n_fail++; $display("FAIL trig_drained_valid: got %b want 0", bus0.rd_valid); end
        n_cmp++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL trig_drained_count: got %0d want 0", cnt0); end
        n_cmp++; if (st0 !== 2'd3) begin n_fail++; $display("FAIL trig_drained_state: got %0d want 3", st0); end
    endtask

    task automatic test_ring_overwrite();
        te1 = 1'b0; tp1 = 8'h00;
        bus1.rd_ready = 1'b1;
        pulse_arm1();
        for (int p = 8'h10; p <= 8'h15; p++) ret1(8'(p));
        n_cmp++; if (st1 !== 2'd2) begin n_fail++; $display("FAIL ring_state: got %0d want 2", st1); end
        n_cmp++; if (cnt1 !== 3'd4) begin n_fail++; $display("FAIL ring_count: got %0d want 4", cnt1); end
        n_cmp++; if (ovf1 !== 1'b1) begin n_fail++; $display("FAIL ring_ovf: got %b want 1", ovf1); end
        pulse_stop1();
        n_cmp++; if (st1 !== 2'd3) begin n_fail++; $display("FAIL ring_done: got %0d want 3", st1); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus1.rd_data !== e1(8'(8'h12 + i))) begin n_fail++; $display("FAIL ring_rd_data %0d: got %h want %h", i, bus1.rd_data, e1(8'(8'h12 + i))); end
            tick();
        end
        bus1.rd_ready = 1'b0;
        n_cmp++; if (bus1.rd_valid !== 1'b0) begin n_fail++; $display("FAIL ring_drained_valid: got %b want 0", bus1.rd_valid); end
    endtask

    task automatic test_stop_retire();
        te0 = 1'b1; tp0 = 8'h1E;
        pulse_arm0();
        n_cmp++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL sr_arm_ovf_clear: got %b want 0", ovf0); end
        ret0(8'h1E);
        ret0(8'h1F);
        n_cmp++; if (cnt0 !== 3'd2) begin n_fail++; $display("FAIL sr_count2: got %0d want 2", cnt0); end
        stop0 = 1'b1;
        ret0(8'h20);
        stop0 = 1'b0;
        n_cmp++; if (st0 !== 2'd3) begin n_fail++; $display("FAIL sr_state: got %0d want 3", st0); end
        n_cmp++; if (cnt0 !== 3'd3) begin n_fail++; $display("FAIL sr_count: got %0d want 3", cnt0); end
        n_cmp++; if (bus0.rd_data !== e0(8'h1E)) begin n_fail++; $display("FAIL sr_first: got %h want %h", bus0.rd_data, e0(8'h1E)); end
    endtask

    task automatic test_backpressure();
        bus0.rd_ready = 1'b1; tick();
        bus0.rd_ready = 1'b0;
        n_cmp++; if (bus0.rd_data !== e0(8'h1F)) begin n_fail++; $display("FAIL bp_second: got %h want %h", bus0.rd_data, e0(8'h1F)); end
        tick();
        n_cmp++; if (bus0.rd_data !== e0(8'h1F)) begin n_fail++; $display("FAIL bp_hold: got %h want %h", bus0.rd_data, e0(8'h1F)); end
        n_cmp++; if (cnt0 !== 3'd2) begin n_fail++; $display("FAIL bp_hold_count: got %0d want 2", cnt0); end
        bus0.rd_ready = 1'b1; tick();
        bus0.rd_ready = 1'b0;
        n_cmp++; if (bus0.rd_data !== e0(8'h20)) begin n_fail++; $display("FAIL bp_third: got %h want %h", bus0.rd_data, e0(8'h20)); end
        n_cmp++; if (cnt0 !== 3'd1) begin n_fail++; $display("FAIL bp_count: got %0d want 1", cnt0); end
        bus0.rd_ready = 1'b1; tick();
        bus0.rd_ready = 1'b0;
        n_cmp++; if (bus0.rd_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty_valid: got %b want 0", bus0.rd_valid); end
        n_cmp++; if (st0 !== 2'd3) begin n_fail++; $display("FAIL bp_empty_state: got %0d want 3", st0); end
    endtask

    task automatic test_rearm();
        te1 = 1'b0;
        pulse_arm1();
        for (int p = 8'h30; p <= 8'h35; p++) ret1(8'(p));
        pulse_stop1();
        bus1.rd_ready = 1'b1; tick();
        bus1.rd_ready = 1'b0;
        n_cmp++; if (cnt1 !== 3'd3) begin n_fail++; $display("FAIL rearm_pre_count: got %0d want 3", cnt1); end
        n_cmp++; if (bus1.rd_data !== e1(8'h33)) begin n_fail++; $display("FAIL rearm_pre_data: got %h want %h", bus1.rd_data, e1(8'h33)); end
        n_cmp++; if (ovf1 !== 1'b1) begin n_fail++; $display("FAIL rearm_pre_ovf: got %b want 1", ovf1); end
        arm1 = 1'b1; bus1.rd_ready = 1'b1; tick();
        arm1 = 1'b0; bus1.rd_ready = 1'b0;
        n_cmp++; if (st1 !== 2'd1) begin n_fail++; $display("FAIL rearm_state: got %0d want 1", st1); end
        n_cmp++; if (cnt1 !== 3'd0) begin n_fail++; $display("FAIL rearm_count: got %0d want 0", cnt1); end
        n_cmp++; if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL rearm_ovf: got %b want 0", ovf1); end
        n_cmp++; if (bus1.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rearm_valid: got %b want 0", bus1.rd_valid); end
        ret1(8'h40);
        n_cmp++; if (cnt1 !== 3'd1) begin n_fail++; $display("FAIL rearm_cap_count: got %0d want 1", cnt1); end
        pulse_stop1();
        n_cmp++; if (bus1.rd_data !== e1(8'h40)) begin n_fail++; $display("FAIL rearm_cap_data: got %h want %h", bus1.rd_data, e1(8'h40)); end
    endtask

    task automatic test_reset_mid_capture();
        te0 = 1'b0;
        pulse_arm0();
        ret0(8'h50);
        ret0(8'h51);
        n_cmp++; if (st0 !== 2'd2) begin n_fail++; $display("FAIL rst_pre_state: got %0d want 2", st0); end
        n_cmp++; if (cnt0 !== 3'd2) begin n_fail++; $display("FAIL rst_pre_count: got %0d want 2", cnt0); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (st0 !== 2'd0) begin n_fail++; $display("FAIL rst_async_state: got %0d want 0", st0); end
        n_cmp++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL rst_async_count: got %0d want 0", cnt0); end
        n_cmp++; if (bus0.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b want 0", bus0.rd_valid); end
        n_cmp++; if (st1 !== 2'd0) begin n_fail++; $display("FAIL rst_async_state1: got %0d want 0", st1); end
        tick();
        reset_n = 1'b1;
        tick();
        n_cmp++; if (st0 !== 2'd0) begin n_fail++; $display("FAIL rst_release_state: got %0d want 0", st0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        arm0 = 1'b0; stop0 = 1'b0; te0 = 1'b0; tp0 = 8'h00;
        arm1 = 1'b0; stop1 = 1'b0; te1 = 1'b0; tp1 = 8'h00;
        bus0.retire = 1'b0; bus0.pc_in = '0; bus0.ir_in = '0; bus0.flags_in = '0; bus0.rd_ready = 1'b0;
        bus1.retire = 1'b0; bus1.pc_in = '0; bus1.ir_in = '0; bus1.flags_in = '0; bus1.rd_ready = 1'b0;
        test_reset();
        test_trigger_stop_mode();
        test_ring_overwrite();
        test_stop_retire();
        test_backpressure();
        test_rearm();
        test_reset_mid_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/core_trace_buffer.md
Name: core_trace_buffer

Overview:
- Parametrised instruction-trace capture block for the processor core.
- Records retired-instruction state (PC, IR, Cout/Z/N flags) into an on-chip buffer after a programmable PC trigger.
- Buffered entries are drained through a valid/ready read port.
- Replaces fixed-duration waveform inspection of PC/IR/flags with a bounded, triggerable, mode-selectable hardware trace.

Parameters:
- PC_WIDTH, 8, width of the program counter.
- INSTR_WIDTH, 16, width of the instruction register.
- DEPTH, 16, number of trace entries; power of two, at least 2.
- RING_MODE, 0, selects the full-buffer policy: 0 stops capture when full, 1 overwrites the oldest entry.

Ports:
- clock_50  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- retire  in  1  one-cycle strobe; the core has completed the instruction on pc_in/ir_in.
- pc_in  in  PC_WIDTH  PC of the retiring instruction.
- ir_in  in  INSTR_WIDTH  IR of the retiring instruction.
- flags_in  in  3  {Cout, Z, N} after the retiring instruction.
- arm  in  1  pulse; clears the buffer and starts waiting for the trigger.
- stop  in  1  pulse; ends capture.
- trig_en  in  1  1 = trigger on PC match; 0 = trigger on the first retire.
- trig_pc  in  PC_WIDTH  trigger PC value.
- rd_valid  out  1  rd_data holds the oldest unread entry.
- rd_ready  in  1  consumer accepts rd_data.
- rd_data  out  PC_WIDTH+INSTR_WIDTH+3  entry packed as {flags, ir, pc}, with pc in the LSBs.
- count  out  clog2(DEPTH)+1  number of entries currently stored.
- state_o  out  2  current FSM state.
- overflow  out  1  sticky; set when any entry was overwritten (ring) or dropped (stop mode).

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; write pointer, read pointer and count all 0.
  - overflow=0, rd_valid=0, rd_data=0.
  - Buffer contents are not cleared.
- FSM states: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- IDLE:
  - arm moves to ARMED.
  - stop is ignored.
- ARMED:
  - Entry clears the pointers, count and overflow.
  - If retire && (!trig_en || pc_in==trig_pc): that same instruction is written as entry 0, count becomes 1, and the FSM moves to CAPTURE.
  - stop returns the FSM to DONE with count=0.
  - arm is ignored.
- CAPTURE:
  - Each retire writes one entry at the write pointer, which then increments modulo DEPTH.
  - RING_MODE=0: the write that makes count==DEPTH moves the FSM to DONE the same edge. No retire is possible while count==DEPTH in CAPTURE.
  - RING_MODE=1: a retire when count==DEPTH overwrites the oldest entry. The read pointer advances with the write pointer, count stays at DEPTH, and overflow is set.
  - stop moves the FSM to DONE. If retire and stop occur on the same edge, the retire is captured first.
  - arm is ignored.
- DONE:
  - Retires are not captured. In RING_MODE=0, a retire while count==DEPTH in the first DONE cycle sets overflow.
  - arm moves to ARMED and discards unread entries.
- Readout:
  - rd_valid = (state==IDLE || state==DONE) && count!=0.
  - rd_data = buffer[read pointer], show-ahead (combinational from the registered pointer).
  - A transfer occurs when rd_valid && rd_ready: the read pointer increments modulo DEPTH and count decrements.
  - Reads are blocked in ARMED and CAPTURE; rd_ready is ignored there.
  - arm and a read transfer on the same edge in DONE: arm wins and no entry is consumed.
  - Once count reaches 0, rd_valid drops on the next cycle and the FSM stays in DONE.
- Pointers: wrap modulo DEPTH. count ranges 0..DEPTH and never exceeds DEPTH.
- Latency: an entry written on edge N is readable from edge N+1, provided the FSM has left CAPTURE.
- Reset mid-capture or mid-readout: all state returns to reset values immediately. A partial trace is lost.

Test Plan:
- DEPTH=4, RING_MODE=0, trig_en=1, trig_pc=8'h05:
  - Stimulus: arm, then retire PCs 01..0A with ir=16'hA000+pc and flags=3'b010.
  - Required: capture starts at PC 05; FSM reaches DONE after PC 08; count=4.
  - Reads return pc 05,06,07,08 with ir A005..A008; rd_valid then drops.
  - Later retires at PC 09/0A are not captured.
- RING_MODE=1, DEPTH=4, trig_en=0:
  - Stimulus: arm; retire PCs 10..15; stop.
  - Required: count=4, overflow=1; reads return 12,13,14,15.
- Same-edge stop+retire at PC 20 after entries 1E,1F (RING_MODE=0, DEPTH=4):
  - Required: count=3; reads return 1E,1F,20.
- Readout backpressure:
  - Stimulus: rd_ready toggles 1,0,1 over three cycles.
  - Required: rd_data holds steady while rd_ready=0; exactly two entries consumed; count decremented by 2.
- Re-arm while in DONE with 3 unread entries, arm and rd_ready asserted on the same edge:
  - Required: FSM goes to ARMED; count=0, overflow=0; rd_valid=0.
- Reset mid-CAPTURE:
  - Stimulus: pull reset_n low asynchronously between clock edges after 2 entries are captured.
  - Required: state_o=0, count=0, rd_valid=0 immediately, with no clock edge needed.
